adder_compute: RTL and testbench
================================

Name: adder_compute

Overview:
- Compute engine for the vector adder accelerator; sits directly downstream of the host CSR block.
- Consumes launch, length, a_addr, b_addr and c_addr from the CSR block.
- Streams vectors A and B from device memory one element at a time, writes C[i] = A[i] + B[i] back to memory.
- On completion, returns a finish pulse and the run's cycle count to the CSR block.

Parameters:
- HOST_DATA_BITS, 32, width of the CSR-side length, address and counter values.
- MEM_LEN_BITS, 8, width of the memory request burst-length field.
- MEM_ADDR_BITS, 64, width of the memory byte address.
- MEM_DATA_BITS, 64, width of the memory data word; one vector element per word.

Ports:
- clock  in  1  sole clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset; asserted (0) forces the reset state immediately, independent of clock.
- launch  in  1  level start request from CSR (control bit 0).
- finish  out  1  single-cycle completion pulse to CSR.
- event_counter_valid  out  1  pulses together with finish.
- event_counter_value  out  HOST_DATA_BITS  cycle count of the run.
- length  in  HOST_DATA_BITS  number of elements.
- a_addr  in  HOST_DATA_BITS  byte base address of A.
- b_addr  in  HOST_DATA_BITS  byte base address of B.
- c_addr  in  HOST_DATA_BITS  byte base address of C.
- mem_req_valid  out  1  single-cycle memory request pulse; no backpressure.
- mem_req_opcode  out  1  0 = read, 1 = write.
- mem_req_len  out  MEM_LEN_BITS  burst length minus one; always 0.
- mem_req_addr  out  MEM_ADDR_BITS  byte address.
- mem_wr_valid  out  1  write data valid, single cycle.
- mem_wr_bits  out  MEM_DATA_BITS  write data.
- mem_rd_valid  in  1  read data valid.
- mem_rd_bits  in  MEM_DATA_BITS  read data.
- mem_rd_deq  out  1  read data consumed; combinational, equals mem_rd_valid while in a data-wait state, else 0.

Behaviour:
- Reset: state IDLE. Element index, cycle counter, A register and all outputs are 0.
- Reset asserted mid-run: the run is abandoned immediately. No finish pulse, and no further memory requests after reset releases.
- FSM states: IDLE, RD_A_REQ, RD_A_DATA, RD_B_REQ, RD_B_DATA, WR_REQ, WR_DATA, DONE.
- IDLE:
  - Stay while launch = 0.
  - On launch = 1: latch length and the three addresses, clear index and counter.
  - Go to DONE if length == 0, else RD_A_REQ.
- RD_A_REQ: mem_req_valid = 1, opcode 0, addr = zero-extended a_addr + index*8. Next state RD_A_DATA.
- RD_A_DATA: wait for mem_rd_valid. On valid: capture mem_rd_bits into the A register, assert mem_rd_deq, go to RD_B_REQ.
- RD_B_REQ / RD_B_DATA: same as the A states using b_addr. The captured B value goes to the adder.
- WR_REQ: mem_req_valid = 1, opcode 1, addr = c_addr + index*8. Next state WR_DATA.
- WR_DATA:
  - mem_wr_valid = 1; mem_wr_bits = (A + B) mod 2^MEM_DATA_BITS. Carry is discarded.
  - Increment index. Go to DONE if the new index == latched length, else RD_A_REQ.
- DONE: finish = 1 and event_counter_valid = 1 for exactly one cycle; then IDLE.
- Address arithmetic:
  - Computed at MEM_ADDR_BITS; base addresses are zero-extended.
  - index*8 wraps modulo 2^MEM_ADDR_BITS.
- Cycle counter:
  - Cleared in the IDLE launch cycle.
  - Increments by 1 every cycle in any state other than IDLE and DONE; wraps at 2^HOST_DATA_BITS.
  - event_counter_value drives the counter register at all times.
- Retrigger: the CSR clears launch on the edge ending DONE. A launch still sampled high in IDLE starts a new run, which is legal.
- Changes to length or addresses during a run are ignored, because the values are latched at launch.
- mem_rd_valid outside RD_A_DATA/RD_B_DATA is ignored and mem_rd_deq stays 0.
- Outputs are registered except mem_rd_deq and the combinational decode of the FSM state.

Test Plan:
- Reset check: hold reset = 0 while toggling launch -> no mem_req_valid, finish = 0; release reset with launch = 0 -> stays IDLE.
- Basic run with a 1-cycle read-latency memory model:
  - Stimulus: length = 3, a_addr = 0x1000, b_addr = 0x2000, c_addr = 0x3000, A = {1,2,3}, B = {10,20,30}.
  - Required: writes {11,22,33} to 0x3000/0x3008/0x3010; a single finish pulse; event_counter_value = 18.
- Zero length: length = 0, launch -> no memory traffic, finish on the 2nd cycle, event_counter_value = 0.
- Overflow: A[0] = 0xFFFF_FFFF_FFFF_FFFF, B[0] = 2, length = 1 -> mem_wr_bits = 1.
- Variable latency: random 0-5 cycle read-valid delays, length = 8 -> correct sums; mem_rd_deq asserted exactly once per read; counter equals the measured cycles.
- Mid-run reset: assert reset during RD_B_DATA of element 1 -> outputs 0 asynchronously; after release with launch = 0, no finish pulse and no memory requests.

Source files
------------

// File: rtl/adder_compute.sv
// Vector-add compute engine: streams A[i] and B[i] from device memory, writes
// C[i] = A[i] + B[i] back, then reports completion and the run's cycle count.
module adder_compute #(
  parameter int unsigned HOST_DATA_BITS = 32,
  parameter int unsigned MEM_LEN_BITS   = 8,
  parameter int unsigned MEM_ADDR_BITS  = 64,
  parameter int unsigned MEM_DATA_BITS  = 64
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      launch,
  output logic                      finish,
  output logic                      event_counter_valid,
  output logic [HOST_DATA_BITS-1:0] event_counter_value,
  input  logic [HOST_DATA_BITS-1:0] length,
  input  logic [HOST_DATA_BITS-1:0] a_addr,
  input  logic [HOST_DATA_BITS-1:0] b_addr,
  input  logic [HOST_DATA_BITS-1:0] c_addr,
  output logic                      mem_req_valid,
  output logic                      mem_req_opcode,
  output logic [MEM_LEN_BITS-1:0]   mem_req_len,
  output logic [MEM_ADDR_BITS-1:0]  mem_req_addr,
  output logic                      mem_wr_valid,
  output logic [MEM_DATA_BITS-1:0]  mem_wr_bits,
  input  logic                      mem_rd_valid,
  input  logic [MEM_DATA_BITS-1:0]  mem_rd_bits,
  output logic                      mem_rd_deq
);

  localparam int unsigned ELEM_SHIFT = 3;  // one 8-byte element per memory word

  typedef enum logic [2:0] {
    IDLE, RD_A_REQ, RD_A_DATA, RD_B_REQ, RD_B_DATA, WR_REQ, WR_DATA, DONE
  } state_e;

  state_e                    state_q, state_d;
  logic [HOST_DATA_BITS-1:0] len_q, len_d;
  logic [HOST_DATA_BITS-1:0] a_base_q, a_base_d;
  logic [HOST_DATA_BITS-1:0] b_base_q, b_base_d;
  logic [HOST_DATA_BITS-1:0] c_base_q, c_base_d;
  logic [HOST_DATA_BITS-1:0] idx_q, idx_d;
  logic [HOST_DATA_BITS-1:0] cnt_q, cnt_d;
  logic [MEM_DATA_BITS-1:0]  a_q, a_d;
  logic [MEM_DATA_BITS-1:0]  b_q, b_d;

  logic                      req_valid_q, req_valid_d;
  logic                      req_op_q, req_op_d;
  logic [MEM_ADDR_BITS-1:0]  req_addr_q, req_addr_d;
  logic                      wr_valid_q, wr_valid_d;
  logic [MEM_DATA_BITS-1:0]  wr_bits_q, wr_bits_d;
  logic                      finish_q, finish_d;
  logic [HOST_DATA_BITS-1:0] req_base_c;

  // Next state, datapath updates, and outputs decoded from the upcoming state
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    a_base_d   = a_base_q;
    b_base_d   = b_base_q;
    c_base_d   = c_base_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    req_base_c = c_base_d;

    if (state_q != IDLE && state_q != DONE) begin
      cnt_d = cnt_q + HOST_DATA_BITS'(1);
    end

    case (state_q)
      IDLE: begin
        if (launch) begin
          len_d    = length;
          a_base_d = a_addr;
          b_base_d = b_addr;
          c_base_d = c_addr;
          idx_d    = '0;
          cnt_d    = '0;
          state_d  = (length == '0) ? DONE : RD_A_REQ;
        end
      end
      RD_A_REQ:  state_d = RD_A_DATA;
      RD_A_DATA: begin
        if (mem_rd_valid) begin
          a_d     = mem_rd_bits;
          state_d = RD_B_REQ;
        end
      end
      RD_B_REQ:  state_d = RD_B_DATA;
      RD_B_DATA: begin
        if (mem_rd_valid) begin
          b_d     = mem_rd_bits;
          state_d = WR_REQ;
        end
      end
      WR_REQ:    state_d = WR_DATA;
      WR_DATA: begin
        idx_d   = idx_q + HOST_DATA_BITS'(1);
        state_d = ((idx_q + HOST_DATA_BITS'(1)) == len_q) ? DONE : RD_A_REQ;
      end
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    case (state_d)
      RD_A_REQ: req_base_c = a_base_d;
      RD_B_REQ: req_base_c = b_base_d;
      default:  req_base_c = c_base_d;
    endcase

    req_valid_d = (state_d == RD_A_REQ) || (state_d == RD_B_REQ) || (state_d == WR_REQ);
    req_op_d    = (state_d == WR_REQ);
    req_addr_d  = req_valid_d ? (MEM_ADDR_BITS'(req_base_c) + (MEM_ADDR_BITS'(idx_d) << ELEM_SHIFT))
                              : '0;
    wr_valid_d  = (state_d == WR_DATA);
    wr_bits_d   = wr_valid_d ? (a_q + b_q) : '0;
    finish_d    = (state_d == DONE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      len_q       <= '0;
      a_base_q    <= '0;
      b_base_q    <= '0;
      c_base_q    <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      req_valid_q <= 1'b0;
      req_op_q    <= 1'b0;
      req_addr_q  <= '0;
      wr_valid_q  <= 1'b0;
      wr_bits_q   <= '0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      a_base_q    <= a_base_d;
      b_base_q    <= b_base_d;
      c_base_q    <= c_base_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      req_valid_q <= req_valid_d;
      req_op_q    <= req_op_d;
      req_addr_q  <= req_addr_d;
      wr_valid_q  <= wr_valid_d;
      wr_bits_q   <= wr_bits_d;
      finish_q    <= finish_d;
    end
  end

  assign finish              = finish_q;
  assign event_counter_valid = finish_q;
  assign event_counter_value = cnt_q;
  assign mem_req_valid       = req_valid_q;
  assign mem_req_opcode      = req_op_q;
  assign mem_req_len         = '0;
  assign mem_req_addr        = req_addr_q;
  assign mem_wr_valid        = wr_valid_q;
  assign mem_wr_bits         = wr_bits_q;
  // Read data is only consumed while the engine is waiting for it
  assign mem_rd_deq          = mem_rd_valid && ((state_q == RD_A_DATA) || (state_q == RD_B_DATA));

endmodule

// File: tb/tb_adder_compute.sv
// Bench for adder_compute: behavioural memory with per-read latency, run-level
// expectations computed from element values, addresses and latencies.
module tb_adder_compute;

  logic        clock;
  logic        reset;
  logic        launch;
  logic        finish;
  logic        event_counter_valid;
  logic [31:0] event_counter_value;
  logic [31:0] length, a_addr, b_addr, c_addr;
  logic        mem_req_valid, mem_req_opcode;
  logic [7:0]  mem_req_len;
  logic [63:0] mem_req_addr;
  logic        mem_wr_valid;
  logic [63:0] mem_wr_bits;
  logic        mem_rd_valid;
  logic [63:0] mem_rd_bits;
  logic        mem_rd_deq;

  adder_compute dut (
    .clock(clock), .reset(reset), .launch(launch), .finish(finish),
    .event_counter_valid(event_counter_valid), .event_counter_value(event_counter_value),
    .length(length), .a_addr(a_addr), .b_addr(b_addr), .c_addr(c_addr),
    .mem_req_valid(mem_req_valid), .mem_req_opcode(mem_req_opcode), .mem_req_len(mem_req_len),
    .mem_req_addr(mem_req_addr), .mem_wr_valid(mem_wr_valid), .mem_wr_bits(mem_wr_bits),
    .mem_rd_valid(mem_rd_valid), .mem_rd_bits(mem_rd_bits), .mem_rd_deq(mem_rd_deq)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_cmp;
  int n_fail;

  // Memory image (bench-owned) and per-read latency table indexed by read number
  logic [63:0] mem [logic [63:0]];
  int          delay_tab [256];
  int          flush_req;

  // Written only by the memory model process
  int          rd_cnt, wr_cnt, deq_cnt, len_bad, deq_bad, flush_ack;
  logic [63:0] wr_log_addr [256];
  logic [63:0] wr_log_data [256];

  initial begin : mem_model
    bit          pending, consumed;
    int          cd;
    logic [63:0] pend_data, wr_addr_last;
    pending = 0; consumed = 0; cd = 0; pend_data = '0; wr_addr_last = '0;
    mem_rd_valid = 1'b0;
    mem_rd_bits  = '0;
    forever begin
      @(negedge clock);
      if (flush_req != flush_ack) begin
        flush_ack = flush_req;
        pending = 0; consumed = 0;
        mem_rd_valid = 1'b0; mem_rd_bits = '0;
      end
      if (consumed) begin
        mem_rd_valid = 1'b0; mem_rd_bits = '0; consumed = 0;
      end
      if (pending) begin
        if (cd == 0) begin
          mem_rd_valid = 1'b1; mem_rd_bits = pend_data; pending = 0;
        end else begin
          cd--;
        end
      end
      if (mem_req_valid) begin
        if (mem_req_len != 8'd0) len_bad++;
        if (!mem_req_opcode) begin
          pending   = 1;
          cd        = delay_tab[rd_cnt % 256];
          pend_data = mem.exists(mem_req_addr) ? mem[mem_req_addr] : 64'd0;
          rd_cnt++;
        end else begin
          wr_addr_last = mem_req_addr;
        end
      end
      if (mem_wr_valid) begin
        wr_log_addr[wr_cnt % 256] = wr_addr_last;
        wr_log_data[wr_cnt % 256] = mem_wr_bits;
        wr_cnt++;
      end
      #1;
      if (mem_rd_valid && mem_rd_deq) begin
        consumed = 1;
        deq_cnt++;
      end
      if (mem_rd_deq && !mem_rd_valid) deq_bad++;
    end
  end

  // Launch a run, scramble CSR inputs after launch, and time it until finish
  task automatic do_run(input int len, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, output int cycles, output bit done,
                        output logic ecv, output logic [31:0] cnt_val, output logic fin_after);
    @(negedge clock);
    length = 32'(len); a_addr = a; b_addr = b; c_addr = c; launch = 1'b1;
    @(negedge clock);
    launch = 1'b0;
    length = $urandom; a_addr = $urandom; b_addr = $urandom; c_addr = $urandom;
    cycles = 0; done = 0; ecv = 1'b0; cnt_val = '0; fin_after = 1'bx;
    for (int k = 0; k < 4000 && !done; k++) begin
      if (finish) begin
        done = 1; ecv = event_counter_valid; cnt_val = event_counter_value;
      end else begin
        cycles++;
        @(negedge clock);
      end
    end
    if (done) begin
      @(negedge clock);
      fin_after = finish;
    end
  endtask

  task automatic test_reset();
    int act;
    length = 32'd4; a_addr = 32'h100; b_addr = 32'h200; c_addr = 32'h300;
    act = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      launch = ~launch;
      #1;
      if (mem_req_valid || finish || mem_wr_valid) act++;
    end
    n_cmp++;
    if (act !== 0) begin
      n_fail++; $display("FAIL reset_hold_activity: got %0d active cycles, expected 0", act);
    end
    n_cmp++;
    if ({finish, event_counter_valid, mem_req_valid, mem_req_opcode, mem_wr_valid, mem_rd_deq} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b, expected 000000",
        {finish, event_counter_valid, mem_req_valid, mem_req_opcode, mem_wr_valid, mem_rd_deq});
    end
    n_cmp++;
    if (event_counter_value !== 32'd0 || mem_req_addr !== 64'd0 || mem_wr_bits !== 64'd0 || mem_req_len !== 8'd0) begin
      n_fail++; $display("FAIL reset_values: got cnt=%h addr=%h wr=%h len=%h, expected all 0",
        event_counter_value, mem_req_addr, mem_wr_bits, mem_req_len);
    end
    @(negedge clock);
    launch = 1'b0; reset = 1'b1;
    act = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      #1;
      if (mem_req_valid || finish) act++;
    end
    n_cmp++;
    if (act !== 0) begin
      n_fail++; $display("FAIL idle_after_reset: got %0d active cycles, expected 0", act);
    end
  endtask

  task automatic test_basic();
    int base_rd, base_wr, base_deq, cycles, exp_cycles, wi;
    bit done; logic ecv, fin_after; logic [31:0] cnt_val; logic [63:0] ea, ed;
    base_rd = rd_cnt; base_wr = wr_cnt; base_deq = deq_cnt;
    for (int i = 0; i < 3; i++) begin
      mem[64'h1000 + 64'(8 * i)] = 64'(i + 1);
      mem[64'h2000 + 64'(8 * i)] = 64'(10 * (i + 1));
    end
    for (int k = 0; k < 6; k++) delay_tab[(base_rd + k) % 256] = 0;
    exp_cycles = 6 * 3;
    do_run(3, 32'h1000, 32'h2000, 32'h3000, cycles, done, ecv, cnt_val, fin_after);
    n_cmp++;
    if (!done) begin n_fail++; $display("FAIL basic_timeout: got no finish, expected finish"); end
    n_cmp++;
    if (cycles !== exp_cycles) begin n_fail++; $display("FAIL basic_cycles: got %0d, expected %0d", cycles, exp_cycles); end
    n_cmp++;
    if (cnt_val !== 32'(exp_cycles)) begin n_fail++; $display("FAIL basic_counter: got %0d, expected %0d", cnt_val, exp_cycles); end
    n_cmp++;
    if (ecv !== 1'b1 || fin_after !== 1'b0) begin
      n_fail++; $display("FAIL basic_pulse: got ecv=%b finish_next=%b, expected 1/0", ecv, fin_after);
    end
    n_cmp++;
    if (wr_cnt - base_wr !== 3 || rd_cnt - base_rd !== 6 || deq_cnt - base_deq !== 6) begin
      n_fail++; $display("FAIL basic_traffic: got wr=%0d rd=%0d deq=%0d, expected 3/6/6",
        wr_cnt - base_wr, rd_cnt - base_rd, deq_cnt - base_deq);
    end
    for (int i = 0; i < 3; i++) begin
      wi = (base_wr + i) % 256;
      ea = 64'h3000 + 64'(8 * i);
      ed = mem[64'h1000 + 64'(8 * i)] + mem[64'h2000 + 64'(8 * i)];
      n_cmp++;
      if (wr_log_addr[wi] !== ea || wr_log_data[wi] !== ed) begin
        n_fail++; $display("FAIL basic_write[%0d]: got addr=%h data=%0d, expected addr=%h data=%0d",
          i, wr_log_addr[wi], wr_log_data[wi], ea, ed);
      end
    end
  endtask

  task automatic test_zero_length();
    int base_rd, base_wr, cycles;
    bit done; logic ecv, fin_after; logic [31:0] cnt_val;
    base_rd = rd_cnt; base_wr = wr_cnt;
    do_run(0, 32'h1000, 32'h2000, 32'h3000, cycles, done, ecv, cnt_val, fin_after);
    n_cmp++;
    if (!done || cycles !== 0) begin
      n_fail++; $display("FAIL zero_finish_timing: got done=%0d after %0d cycles, expected finish on 2nd cycle", done, cycles);
    end
    n_cmp++;
    if (cnt_val !== 32'd0 || ecv !== 1'b1 || fin_after !== 1'b0) begin
      n_fail++; $display("FAIL zero_counter: got cnt=%0d ecv=%b finish_next=%b, expected 0/1/0", cnt_val, ecv, fin_after);
    end
    n_cmp++;
    if (rd_cnt !== base_rd || wr_cnt !== base_wr) begin
      n_fail++; $display("FAIL zero_traffic: got rd=%0d wr=%0d, expected 0/0", rd_cnt - base_rd, wr_cnt - base_wr);
    end
  endtask

  task automatic test_overflow();
    int base_rd, base_wr, cycles;
    bit done; logic ecv, fin_after; logic [31:0] cnt_val;
    base_rd = rd_cnt; base_wr = wr_cnt;
    mem[64'h7000] = 64'hFFFF_FFFF_FFFF_FFFF;
    mem[64'h8000] = 64'd2;
    delay_tab[base_rd % 256] = 0; delay_tab[(base_rd + 1) % 256] = 0;
    do_run(1, 32'h7000, 32'h8000, 32'h9000, cycles, done, ecv, cnt_val, fin_after);
    n_cmp++;
    if (!done || wr_cnt - base_wr !== 1) begin
      n_fail++; $display("FAIL overflow_run: got done=%0d writes=%0d, expected 1/1", done, wr_cnt - base_wr);
    end
    n_cmp++;
    if (wr_log_data[base_wr % 256] !== 64'd1 || wr_log_addr[base_wr % 256] !== 64'h9000) begin
      n_fail++; $display("FAIL overflow_sum: got addr=%h data=%h, expected addr=9000 data=1",
        wr_log_addr[base_wr % 256], wr_log_data[base_wr % 256]);
    end
    n_cmp++;
    if (cnt_val !== 32'd6) begin n_fail++; $display("FAIL overflow_counter: got %0d, expected 6", cnt_val); end
  endtask

  task automatic test_variable_latency();
    int base_rd, base_wr, base_deq, cycles, exp_cycles, wi, len;
    bit done; logic ecv, fin_after; logic [31:0] cnt_val, a, b, c;
    logic [63:0] ea, ed;
    len = 8;
    for (int it = 0; it < 3; it++) begin
      base_rd = rd_cnt; base_wr = wr_cnt; base_deq = deq_cnt;
      a = (it == 0) ? 32'hFFFF_FFF0 : $urandom;
      b = $urandom; c = (it == 1) ? 32'hFFFF_FFE8 : $urandom;
      for (int i = 0; i < len; i++) begin
        mem[64'(a) + 64'(8 * i)] = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
        mem[64'(b) + 64'(8 * i)] = {$urandom, $urandom};
      end
      exp_cycles = 6 * len;
      for (int k = 0; k < 2 * len; k++) begin
        delay_tab[(base_rd + k) % 256] = $urandom_range(0, 5);
        exp_cycles += delay_tab[(base_rd + k) % 256];
      end
      do_run(len, a, b, c, cycles, done, ecv, cnt_val, fin_after);
      n_cmp++;
      if (!done) begin n_fail++; $display("FAIL varlat%0d_timeout: got no finish, expected finish", it); end
      n_cmp++;
      if (cycles !== exp_cycles || cnt_val !== 32'(cycles)) begin
        n_fail++; $display("FAIL varlat%0d_cycles: got measured=%0d counter=%0d, expected %0d",
          it, cycles, cnt_val, exp_cycles);
      end
      n_cmp++;
      if (deq_cnt - base_deq !== 2 * len || rd_cnt - base_rd !== 2 * len || wr_cnt - base_wr !== len) begin
        n_fail++; $display("FAIL varlat%0d_traffic: got deq=%0d rd=%0d wr=%0d, expected %0d/%0d/%0d",
          it, deq_cnt - base_deq, rd_cnt - base_rd, wr_cnt - base_wr, 2 * len, 2 * len, len);
      end
      for (int i = 0; i < len; i++) begin
        wi = (base_wr + i) % 256;
        ea = 64'(c) + 64'(8 * i);
        ed = mem[64'(a) + 64'(8 * i)] + mem[64'(b) + 64'(8 * i)];
        n_cmp++;
        if (wr_log_addr[wi] !== ea || wr_log_data[wi] !== ed) begin
          n_fail++; $display("FAIL varlat%0d_write[%0d]: got addr=%h data=%h, expected addr=%h data=%h",
            it, i, wr_log_addr[wi], wr_log_data[wi], ea, ed);
        end
      end
    end
    n_cmp++;
    if (len_bad !== 0 || deq_bad !== 0) begin
      n_fail++; $display("FAIL req_len_deq: got bad_len=%0d bad_deq=%0d, expected 0/0", len_bad, deq_bad);
    end
  endtask

  task automatic test_midrun_reset();
    int base_rd, act;
    bit found;
    base_rd = rd_cnt;
    for (int k = 0; k < 8; k++) delay_tab[(base_rd + k) % 256] = (k == 3) ? 5 : 0;
    @(negedge clock);
    length = 32'd4; a_addr = 32'h4000; b_addr = 32'h5000; c_addr = 32'h6000; launch = 1'b1;
    @(negedge clock);
    launch = 1'b0;
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (mem_req_valid && !mem_req_opcode && mem_req_addr == 64'h5008) found = 1;
      else @(negedge clock);
    end
    n_cmp++;
    if (!found) begin n_fail++; $display("FAIL midrun_locate: got no B[1] read, expected one"); end
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({finish, event_counter_valid, mem_req_valid, mem_wr_valid, mem_rd_deq} !== 5'b0 ||
        event_counter_value !== 32'd0 || mem_req_addr !== 64'd0) begin
      n_fail++; $display("FAIL midrun_async_clear: got flags=%b cnt=%0d addr=%h, expected all 0",
        {finish, event_counter_valid, mem_req_valid, mem_wr_valid, mem_rd_deq}, event_counter_value, mem_req_addr);
    end
    repeat (3) @(negedge clock);
    reset = 1'b1;
    act = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      #2;
      if (mem_req_valid || finish || mem_wr_valid || mem_rd_deq) act++;
    end
    n_cmp++;
    if (act !== 0) begin n_fail++; $display("FAIL midrun_quiet: got %0d active cycles, expected 0", act); end
    n_cmp++;
    if (event_counter_value !== 32'd0) begin
      n_fail++; $display("FAIL midrun_counter: got %0d, expected 0", event_counter_value);
    end
    flush_req++;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    reset = 1'b0; launch = 1'b0;
    length = '0; a_addr = '0; b_addr = '0; c_addr = '0;
    n_cmp = 0; n_fail = 0;
    test_reset();
    test_basic();
    test_zero_length();
    test_overflow();
    test_variable_latency();
    test_midrun_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
